// File: rtl/sap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sap_ctrl_pkg
//   Shared types and constants for the SAP-2 control sequencer:
//   opcode encoding, FSM states, jump condition codes, A-register source
//   select values and a helper that evaluates a jump condition.
//   Configuration macro used by the sequencer: SINGLE_STEP_EN.
// -----------------------------------------------------------------------------
package sap_ctrl_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_ALU    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_CARRY  = 2'd1,
    COND_ZERO   = 2'd2
  } cond_e;

  localparam logic [1:0] A_SRC_RAM = 2'd0;
  localparam logic [1:0] A_SRC_ALU = 2'd1;
  localparam logic [1:0] A_SRC_IMM = 2'd2;

  // True when a jump with condition code 'cond' should be taken.
  function automatic logic cond_met(input logic [1:0] cond,
                                    input logic carry,
                                    input logic zero);
    logic taken;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_CARRY:  taken = carry;
      COND_ZERO:   taken = zero;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_sequencer_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
//   Combinational opcode classifier for the control sequencer.
//   Ports:
//     opcode    in   OPC_W  opcode field of the IR
//     needs_mem out  1      instruction has an operand RAM access (LDA/ADD/SUB/STA)
//     is_jump   out  1      JMP/JC/JZ
//     cond      out  2      jump condition (cond_e)
//     is_ldi    out  1      load immediate
//     is_out    out  1      output register load
//     is_halt   out  1      HLT
//     is_load   out  1      LDA
//     is_store  out  1      STA
//     is_sub    out  1      SUB
//   Undefined opcodes decode with every class bit low, i.e. as NOP.
// -----------------------------------------------------------------------------
module instr_decoder
  import sap_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             needs_mem,
  output logic             is_jump,
  output logic [1:0]       cond,
  output logic             is_ldi,
  output logic             is_out,
  output logic             is_halt,
  output logic             is_load,
  output logic             is_store,
  output logic             is_sub
);

  // Opcode to instruction class lookup.
  always_comb begin
    needs_mem = 1'b0;
    is_jump   = 1'b0;
    cond      = COND_ALWAYS;
    is_ldi    = 1'b0;
    is_out    = 1'b0;
    is_halt   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_sub    = 1'b0;
    case (opcode)
      OP_LDA: begin needs_mem = 1'b1; is_load  = 1'b1; end
      OP_ADD: begin needs_mem = 1'b1; end
      OP_SUB: begin needs_mem = 1'b1; is_sub   = 1'b1; end
      OP_STA: begin needs_mem = 1'b1; is_store = 1'b1; end
      OP_LDI: begin is_ldi = 1'b1; end
      OP_JMP: begin is_jump = 1'b1; cond = COND_ALWAYS; end
      OP_JC:  begin is_jump = 1'b1; cond = COND_CARRY;  end
      OP_JZ:  begin is_jump = 1'b1; cond = COND_ZERO;   end
      OP_OUT: begin is_out  = 1'b1; end
      OP_HLT: begin is_halt = 1'b1; end
      default: begin end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Fetch/decode/execute FSM of the SAP-2 core. Drives the PC increment/load,
//   the shared RAM port (instruction fetch vs operand access), IR, A/B and
//   output register strobes. Strobes are combinational from state, IR and
//   mem_ready and are forced low while reset_n is asserted.
//   Ports:
//     clk, reset_n (async active-low)
//     instr_in, mem_ready, flag_carry, flag_zero, step      inputs
//     pc_enable, pc_load, pc_load_value, mem_addr_sel, mem_rd, mem_wr,
//     ir_load, a_load, a_src, b_load, alu_sub, out_load, halted  outputs
//   Configuration: define SINGLE_STEP_EN to make the FSM wait in S_FETCH for
//   a step pulse before each instruction; otherwise step is ignored.
// -----------------------------------------------------------------------------
module control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int OPCODE_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              mem_ready,
  input  logic              flag_carry,
  input  logic              flag_zero,
  input  logic              step,
  output logic              pc_enable,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_value,
  output logic              mem_addr_sel,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              ir_load,
  output logic              a_load,
  output logic [1:0]        a_src,
  output logic              b_load,
  output logic              alu_sub,
  output logic              out_load,
  output logic              halted
);

  state_e              state_r;
  state_e              next_state_s;
  logic [DATA_W-1:0]   ir_r;
  logic [OPCODE_W-1:0] opcode_s;
  logic                fetch_go_s;

  logic       needs_mem_s;
  logic       is_jump_s;
  logic [1:0] cond_s;
  logic       is_ldi_s;
  logic       is_out_s;
  logic       is_halt_s;
  logic       is_load_s;
  logic       is_store_s;
  logic       is_sub_s;

  assign opcode_s      = ir_r[DATA_W-1 -: OPCODE_W];
  assign pc_load_value = ir_r[ADDR_W-1:0];

  instr_decoder u_decoder (
    .opcode    (opcode_s),
    .needs_mem (needs_mem_s),
    .is_jump   (is_jump_s),
    .cond      (cond_s),
    .is_ldi    (is_ldi_s),
    .is_out    (is_out_s),
    .is_halt   (is_halt_s),
    .is_load   (is_load_s),
    .is_store  (is_store_s),
    .is_sub    (is_sub_s)
  );

`ifdef SINGLE_STEP_EN
  logic step_armed_r;

  // Step latch: armed by a step seen in S_FETCH, consumed by the fetch it
  // releases. Steps outside S_FETCH are dropped, so they never queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_armed_r <= 1'b0;
    end else if (state_r == S_FETCH) begin
      if (!step_armed_r) begin
        step_armed_r <= step;
      end else if (mem_ready) begin
        step_armed_r <= 1'b0;
      end else begin
        step_armed_r <= step_armed_r;
      end
    end else begin
      step_armed_r <= 1'b0;
    end
  end

  assign fetch_go_s = step_armed_r;
`else
  logic unused_step_s;
  assign unused_step_s = step;
  assign fetch_go_s    = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Instruction register, captured at the end of a completed fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_r <= {DATA_W{1'b0}};
    end else if (ir_load) begin
      ir_r <= instr_in;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Next-state and strobe decode; reset_n gates every strobe so an aborted
  // instruction never leaves a partial strobe behind.
  always_comb begin
    next_state_s = state_r;
    pc_enable    = 1'b0;
    pc_load      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    ir_load      = 1'b0;
    a_load       = 1'b0;
    a_src        = A_SRC_RAM;
    b_load       = 1'b0;
    alu_sub      = 1'b0;
    out_load     = 1'b0;
    halted       = 1'b0;
    if (!reset_n) begin
      next_state_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (fetch_go_s) begin
            mem_rd = 1'b1;
            if (mem_ready) begin
              ir_load      = 1'b1;
              pc_enable    = 1'b1;
              next_state_s = S_DECODE;
            end else begin
              next_state_s = S_FETCH;
            end
          end else begin
            next_state_s = S_FETCH;
          end
        end
        S_DECODE: begin
          if (is_halt_s) begin
            next_state_s = S_HALT;
          end else if (needs_mem_s) begin
            next_state_s = S_MEM;
          end else begin
            next_state_s = S_FETCH;
            if (is_ldi_s) begin
              a_load = 1'b1;
              a_src  = A_SRC_IMM;
            end else if (is_out_s) begin
              out_load = 1'b1;
            end else if (is_jump_s) begin
              pc_load = cond_met(cond_s, flag_carry, flag_zero);
            end else begin
              pc_load = 1'b0;
            end
          end
        end
        S_MEM: begin
          mem_addr_sel = 1'b1;
          if (is_store_s) begin
            mem_wr = 1'b1;
          end else begin
            mem_rd = 1'b1;
          end
          if (mem_ready) begin
            if (is_load_s) begin
              a_load       = 1'b1;
              a_src        = A_SRC_RAM;
              next_state_s = S_FETCH;
            end else if (is_store_s) begin
              next_state_s = S_FETCH;
            end else begin
              b_load       = 1'b1;
              next_state_s = S_ALU;
            end
          end else begin
            next_state_s = S_MEM;
          end
        end
        S_ALU: begin
          a_load       = 1'b1;
          a_src        = A_SRC_ALU;
          alu_sub      = is_sub_s;
          next_state_s = S_FETCH;
        end
        S_HALT: begin
          halted       = 1'b1;
          next_state_s = S_HALT;
        end
        default: begin
          next_state_s = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//   Directed bench for control_sequencer. Each cycle the bench drives RAM
//   data, mem_ready, flags and step at the falling edge, pushes the expected
//   output vector to a scoreboard queue, and pops/compares it just after.
//   Output vector: {pc_enable, pc_load, pc_load_value, mem_addr_sel, mem_rd,
//   mem_wr, ir_load, a_load, a_src, b_load, alu_sub, out_load, halted}.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic       clk;
  logic       reset_n;
  logic [7:0] instr_in;
  logic       mem_ready;
  logic       flag_carry;
  logic       flag_zero;
  logic       step;
  logic       pc_enable;
  logic       pc_load;
  logic [3:0] pc_load_value;
  logic       mem_addr_sel;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_load;
  logic       a_load;
  logic [1:0] a_src;
  logic       b_load;
  logic       alu_sub;
  logic       out_load;
  logic       halted;

  int          total;
  int          bad;
  logic [16:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  exp_ir;

  control_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_in      (instr_in),
    .mem_ready     (mem_ready),
    .flag_carry    (flag_carry),
    .flag_zero     (flag_zero),
    .step          (step),
    .pc_enable     (pc_enable),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .mem_addr_sel  (mem_addr_sel),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .ir_load       (ir_load),
    .a_load        (a_load),
    .a_src         (a_src),
    .b_load        (b_load),
    .alu_sub       (alu_sub),
    .out_load      (out_load),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [16:0] vec(input logic pe, input logic pl,
                                      input logic [3:0] plv, input logic sel,
                                      input logic rd, input logic wr,
                                      input logic irl, input logic al,
                                      input logic [1:0] asrc, input logic bl,
                                      input logic sub, input logic outl,
                                      input logic halt);
    return {pe, pl, plv, sel, rd, wr, irl, al, asrc, bl, sub, outl, halt};
  endfunction

  function automatic logic [16:0] quiet(input logic [3:0] plv);
    return vec(1'b0, 1'b0, plv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [16:0] e);
    logic [16:0] obs;
    logic [16:0] want;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    obs  = {pc_enable, pc_load, pc_load_value, mem_addr_sel, mem_rd, mem_wr,
            ir_load, a_load, a_src, b_load, alu_sub, out_load, halted};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, want);
    end
  endtask

  task automatic cyc(input string tag, input logic [7:0] ins, input logic rdy,
                     input logic c, input logic z, input logic stp,
                     input logic [16:0] e);
    @(negedge clk);
    instr_in   = ins;
    mem_ready  = rdy;
    flag_carry = c;
    flag_zero  = z;
    step       = stp;
    chk(tag, e);
  endtask

  task automatic do_fetch(input string tag, input logic [7:0] ins, input int stalls);
`ifdef SINGLE_STEP_EN
    cyc({tag, "_arm"}, ins, 1'b0, 1'b0, 1'b0, 1'b1, quiet(exp_ir[3:0]));
`endif
    for (int i = 0; i < stalls; i++) begin
      cyc({tag, "_fstall"}, ins, 1'b0, 1'b0, 1'b0, 1'b0,
          vec(1'b0, 1'b0, exp_ir[3:0], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    cyc({tag, "_fetch"}, ins, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b1, 1'b0, exp_ir[3:0], 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_ir = ins;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_ir     = 8'h00;
    reset_n    = 1'b0;
    instr_in   = 8'h00;
    mem_ready  = 1'b0;
    flag_carry = 1'b0;
    flag_zero  = 1'b0;
    step       = 1'b0;
    repeat (2) @(negedge clk);

    // Reset holds every strobe low even with RAM ready.
    cyc("reset", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd0));
    mem_ready = 1'b0;
    reset_n   = 1'b1;

    // LDI 5
    do_fetch("ldi", 8'h55, 0);
    cyc("ldi_exec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));

    // LDA 9 with one fetch stall and two operand stalls
    do_fetch("lda", 8'h19, 1);
    cyc("lda_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd9));
    for (int i = 0; i < 2; i++) begin
      cyc("lda_mstall", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
          vec(1'b0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    cyc("lda_mem", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // SUB 4
    do_fetch("sub", 8'h34, 0);
    cyc("sub_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd4));
    cyc("sub_mem", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc("sub_alu", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0));

    // ADD 1
    do_fetch("add", 8'h21, 0);
    cyc("add_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd1));
    cyc("add_mem", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc("add_alu", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));

    // STA 2 with one write stall
    do_fetch("sta", 8'h42, 0);
    cyc("sta_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd2));
    cyc("sta_mstall", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("sta_mem", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // JZ 12 not taken, then taken
    do_fetch("jz_nt", 8'h8C, 0);
    cyc("jz_nt_dec", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, quiet(4'd12));
    do_fetch("jz_t", 8'h8C, 0);
    cyc("jz_t_dec", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0,
        vec(1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // JC 7 not taken, then taken; JMP 3 unconditional
    do_fetch("jc_nt", 8'h77, 0);
    cyc("jc_nt_dec", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, quiet(4'd7));
    do_fetch("jc_t", 8'h77, 0);
    cyc("jc_t_dec", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0,
        vec(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    do_fetch("jmp", 8'h63, 0);
    cyc("jmp_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // OUT, then an undefined opcode behaving as NOP
    do_fetch("out", 8'hE0, 0);
    cyc("out_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    do_fetch("undef", 8'hA5, 0);
`ifdef SINGLE_STEP_EN
    // A step during decode is dropped; the FSM then waits in fetch.
    cyc("undef_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, quiet(4'd5));
    for (int i = 0; i < 2; i++) begin
      cyc("step_wait", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd5));
    end
`else
    cyc("undef_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd5));
`endif

    // HLT: halted with no strobes for 10 cycles
    do_fetch("hlt", 8'hF0, 0);
    cyc("hlt_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd0));
    for (int i = 0; i < 10; i++) begin
      cyc("halt", 8'h19, 1'b1, 1'b1, 1'b1, 1'b1,
          vec(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    step      = 1'b0;
    chk("halt_reset", quiet(4'd0));
    exp_ir  = 8'h00;
    reset_n = 1'b1;

    // Reset in the middle of an operand access
    do_fetch("lda3", 8'h13, 0);
    cyc("lda3_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd3));
    cyc("lda3_mstall", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
        vec(1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    chk("mem_reset", quiet(4'd0));
    mem_ready = 1'b0;
    exp_ir    = 8'h00;
    reset_n   = 1'b1;
    do_fetch("post_reset", 8'h00, 0);
    cyc("post_reset_dec", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, quiet(4'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
